pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 191 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 3;
  localparam int unsigned LOL_FILTER_DEPTH  = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock and gates the system reset.
// Optional macro PLL_SUP_LOL_FILTER_EN ignores loss-of-lock glitches shorter than 4 cycles in RUN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_fail,
  output logic [7:0] relock_cnt
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_ZERO  = RW'(0);
  localparam logic [RW-1:0] RTY_ONE   = RW'(1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [RW-1:0] retry_d, retry_q;
  logic [RW-1:0] retry_inc_s;
  logic [7:0]    relock_d, relock_q;
  logic          pll_rst_d, pll_rst_q;
  logic          sys_rst_n_d, sys_rst_n_q;
  logic          lock_fail_d, lock_fail_q;
  logic          locked_s;
  logic          lol_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

`ifdef PLL_SUP_LOL_FILTER_EN
  localparam int unsigned   LW       = $clog2(LOL_FILTER_DEPTH);
  localparam logic [LW-1:0] LOL_ZERO = LW'(0);
  localparam logic [LW-1:0] LOL_ONE  = LW'(1);
  localparam logic [LW-1:0] LOL_LAST = LW'(LOL_FILTER_DEPTH - 1);

  logic [LW-1:0] lol_cnt_d, lol_cnt_q;

  // loss of lock acts only on the last of LOL_FILTER_DEPTH consecutive unlocked cycles
  always_comb begin
    lol_s     = 1'b0;
    lol_cnt_d = LOL_ZERO;
    if ((state_q == ST_RUN) && !locked_s) begin
      if (lol_cnt_q == LOL_LAST) begin
        lol_s     = 1'b1;
        lol_cnt_d = LOL_ZERO;
      end else begin
        lol_s     = 1'b0;
        lol_cnt_d = lol_cnt_q + LOL_ONE;
      end
    end else begin
      lol_s     = 1'b0;
      lol_cnt_d = LOL_ZERO;
    end
  end

  // consecutive-unlocked run length register
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lol_cnt_q <= LOL_ZERO;
    end else begin
      lol_cnt_q <= lol_cnt_d;
    end
  end
`else
  assign lol_s = ~locked_s;
`endif

  assign retry_inc_s = retry_q + RTY_ONE;

  // next-state, counter and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    if (restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = CNT_ZERO;
      retry_d = RTY_ZERO;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d   = CNT_ZERO;
            retry_d = retry_inc_s;
            if (retry_inc_s == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PLL_RST;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (lol_s) begin
            state_d  = ST_PLL_RST;
            cnt_d    = CNT_ZERO;
            retry_d  = RTY_ZERO;
            relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = CNT_ZERO;
          retry_d = RTY_ZERO;
        end
      endcase
    end
    // outputs follow the state being entered so they switch on the transition edge
    pll_rst_d   = (state_d == ST_PLL_RST);
    sys_rst_n_d = (state_d == ST_RUN);
    lock_fail_d = (state_d == ST_FAIL);
  end

  // state, counters and registered outputs
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= CNT_ZERO;
      retry_q     <= RTY_ZERO;
      relock_q    <= 8'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign lock_fail  = lock_fail_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench: per-cycle comparison against a phase/countdown model plus literal timing checks.
module tb_pll_lock_supervisor;

  localparam int RSTC  = 4;
  localparam int TMO   = 20;
  localparam int STB   = 8;
  localparam int RETRY = 2;
`ifdef PLL_SUP_LOL_FILTER_EN
  localparam int FILT = 4;
`else
  localparam int FILT = 1;
`endif

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_fail;
  logic [7:0] relock_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // model state: phase, cycles left in phase, failed attempts, relock count, unlocked run
  int   m_phase  = P_RST;
  int   m_left   = RSTC;
  int   m_tries  = 0;
  int   m_relock = 0;
  int   m_drop   = 0;
  logic m_line[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (RSTC),
    .LOCK_TIMEOUT  (TMO),
    .STABLE_CYCLES (STB),
    .MAX_RETRIES   (RETRY)
  ) dut (
    .refclk     (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .lock_fail  (lock_fail),
    .relock_cnt (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_phase  = P_RST;
    m_left   = RSTC;
    m_tries  = 0;
    m_relock = 0;
    m_drop   = 0;
    m_line.delete();
    m_line.push_back(1'b0);
    m_line.push_back(1'b0);
  endtask

  // pll_locked is seen by the sequencer two edges after it is sampled
  task automatic mdl_step();
    logic seen;
    if (!rst_n) begin
      mdl_reset();
    end else begin
      seen = m_line.pop_front();
      m_line.push_back(pll_locked);
      if (restart) begin
        m_phase = P_RST;
        m_left  = RSTC;
        m_tries = 0;
        m_drop  = 0;
      end else begin
        case (m_phase)
          P_RST: begin
            m_left--;
            if (m_left == 0) begin
              m_phase = P_WAIT;
              m_left  = TMO;
            end
          end
          P_WAIT: begin
            if (seen) begin
              m_phase = P_STAB;
              m_left  = STB;
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_tries++;
                if (m_tries == RETRY) m_phase = P_FAIL;
                else begin
                  m_phase = P_RST;
                  m_left  = RSTC;
                end
              end
            end
          end
          P_STAB: begin
            if (!seen) begin
              m_phase = P_WAIT;
              m_left  = TMO;
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_phase = P_RUN;
                m_drop  = 0;
              end
            end
          end
          P_RUN: begin
            m_drop = seen ? 0 : m_drop + 1;
            if (m_drop >= FILT) begin
              m_phase = P_RST;
              m_left  = RSTC;
              m_tries = 0;
              m_drop  = 0;
              if (m_relock < 255) m_relock++;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  // one clock: advance the model with the inputs the DUT samples, then compare on the falling edge
  task automatic tick();
    @(posedge clk);
    mdl_step();
    @(negedge clk);
    cmp("pll_rst", 32'(pll_rst), 32'(m_phase == P_RST));
    cmp("sys_rst_n", 32'(sys_rst_n), 32'(m_phase == P_RUN));
    cmp("lock_fail", 32'(lock_fail), 32'(m_phase == P_FAIL));
    cmp("relock_cnt", 32'(relock_cnt), 32'(m_relock));
  endtask

  task automatic wait_sys(input string name, input int limit);
    int n;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    cmp(name, 32'(sys_rst_n), 32'd1);
  endtask

  initial begin
    int n;
    int rel_exp;
    int run_left;
    mdl_reset();

    // reset values
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    cmp("rst_pll_rst", 32'(pll_rst), 32'd1);
    cmp("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    cmp("rst_lock_fail", 32'(lock_fail), 32'd0);
    cmp("rst_relock", 32'(relock_cnt), 32'd0);

    // no lock ever: two reset pulses, two timeouts, then FAIL
    rst_n = 1'b1;
    n = 0; do begin tick(); n++; end while (pll_rst && n < 50);
    cmp("fail_pulse1_len", n, 4);
    n = 0; do begin tick(); n++; end while (!pll_rst && !lock_fail && n < 100);
    cmp("fail_wait1_len", n, 20);
    n = 0; do begin tick(); n++; end while (pll_rst && n < 50);
    cmp("fail_pulse2_len", n, 4);
    n = 0; do begin tick(); n++; end while (!pll_rst && !lock_fail && n < 100);
    cmp("fail_wait2_len", n, 20);
    cmp("fail_flag", 32'(lock_fail), 32'd1);
    for (int i = 0; i < 30; i++) tick();
    cmp("fail_held", 32'(lock_fail), 32'd1);
    cmp("fail_pll_rst", 32'(pll_rst), 32'd0);
    cmp("fail_sys_rst_n", 32'(sys_rst_n), 32'd0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    cmp("restart_clears_fail", 32'(lock_fail), 32'd0);
    cmp("restart_pll_rst", 32'(pll_rst), 32'd1);
    n = 0; do begin tick(); n++; end while (pll_rst && n < 50);
    cmp("restart_pulse_len", n, 4);

    // clean lock 6 cycles into WAIT_LOCK
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0; do begin tick(); n++; end while (pll_rst && n < 50);
    cmp("lock_pulse_len", n, 4);
    for (int i = 0; i < 6; i++) tick();
    pll_locked = 1'b1;
    n = 0; do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 100);
    cmp("lock_to_sys_rst", n, 11);

    // one-cycle drop while STABLE counter sits at 5
    pll_locked = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n = 0; do begin tick(); n++; end while (pll_rst && n < 50);
    tick();
    tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    cmp("stable_drop_sys_low", 32'(sys_rst_n), 32'd0);
    n = 0; do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 100);
    cmp("stable_drop_relock_latency", n, 11);

    // two-cycle drop in RUN
    for (int i = 0; i < 3; i++) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    tick();
    tick();
    rel_exp = (FILT > 2) ? 0 : 1;
    cmp("drop2_relock", 32'(relock_cnt), 32'(rel_exp));
    cmp("drop2_sys_rst_n", 32'(sys_rst_n), 32'(1 - rel_exp));
    cmp("drop2_pll_rst", 32'(pll_rst), 32'(rel_exp));
    wait_sys("drop2_back_to_run", 100);
    // five-cycle drop is a loss of lock in either build
    pll_locked = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cmp("drop5_relock", 32'(relock_cnt), 32'(rel_exp + 1));
    cmp("drop5_sys_rst_n", 32'(sys_rst_n), 32'd0);

    // randomized lock behaviour with occasional restart and reset
    run_left = 1;
    for (int c = 0; c < 3000; c++) begin
      restart = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      run_left--;
      if (run_left <= 0) begin
        pll_locked = ~pll_locked;
        if (pll_locked) run_left = int'($urandom_range(1, 60));
        else if ($urandom_range(0, 3) == 0) run_left = int'($urandom_range(20, 60));
        else run_left = int'($urandom_range(1, 6));
      end
      tick();
    end
    restart = 1'b0;
    rst_n = 1'b1;

    // relock counter saturation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pll_locked = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_sys("sat_reach_run", 100);
      pll_locked = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      pll_locked = 1'b1;
    end
    wait_sys("sat_final_run", 100);
    cmp("relock_saturated", 32'(relock_cnt), 32'd255);

    // reset while running
    rst_n = 1'b0;
    tick();
    cmp("run_rst_pll_rst", 32'(pll_rst), 32'd1);
    cmp("run_rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    cmp("run_rst_lock_fail", 32'(lock_fail), 32'd0);
    cmp("run_rst_relock", 32'(relock_cnt), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
